// File: rtl/reaction_timer_if.sv
// reaction_timer_if: bundles the reaction timer's control inputs and result
// outputs so the design and its environment share one connection point.
//   arm        - one-cycle pulse, a new light sequence has started
//   go         - lights-out level from the delay block
//   btn        - synchronised player button, active-high level
//   N          - prescaler reload; one time unit = N+1 clk cycles
//   react_time - measured time units, held until the next arm
//   valid      - one-cycle strobe when a result is latched
//   foul       - jump start, held until the next arm
//   ovf        - counter saturated before any press, held until the next arm
//   busy       - measurement in progress (ARMED or TIMING)
// master drives arm/go/btn/N; slave (the timer) drives the results.
interface reaction_timer_if #(
  parameter int WIDTH = 16
);
  logic             arm;
  logic             go;
  logic             btn;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] react_time;
  logic             valid;
  logic             foul;
  logic             ovf;
  logic             busy;

  modport master (
    output arm, go, btn, N,
    input  react_time, valid, foul, ovf, busy
  );

  modport slave (
    input  arm, go, btn, N,
    output react_time, valid, foul, ovf, busy
  );
endinterface

// File: rtl/reaction_timer.sv
// reaction_timer: measures the player's reaction to lights-out.
// Arms on arm, flags a foul if the button is pressed before go, otherwise
// counts prescaled time units (N+1 clk cycles each) from go until the press,
// saturating with ovf if the counter would wrap. A one-cycle valid strobe
// marks every latched result.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   bus_if - reaction_timer_if slave: arm/go/btn/N in,
//            react_time/valid/foul/ovf/busy out
module reaction_timer #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  reaction_timer_if.slave    bus_if
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_TIMING = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             btn_q;
  logic [WIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] react_q, react_d;
  logic             valid_q, valid_d;
  logic             foul_q,  foul_d;
  logic             ovf_q,   ovf_d;

  logic             press;
  logic             tick;
  logic             react_max;

  // Rising edge only: a button already held (even through arm) never counts.
  assign press     = bus_if.btn & ~btn_q;
  assign tick      = (presc_q == '0);
  assign react_max = (react_q == '1);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    react_d = react_q;
    valid_d = 1'b0;
    foul_d  = foul_q;
    ovf_d   = ovf_q;

    // arm outranks press and go in every state, including a restart mid-run.
    if (bus_if.arm) begin
      state_d = S_ARMED;
      react_d = '0;
      foul_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (press) begin
            state_d = S_RESULT;
            foul_d  = 1'b1;
            react_d = '0;
            valid_d = 1'b1;
          end else if (bus_if.go) begin
            state_d = S_TIMING;
            presc_d = bus_if.N;
            react_d = '0;
          end
        end
        S_TIMING: begin
          // Press wins over a same-cycle tick, so that tick's increment is lost.
          if (press) begin
            state_d = S_RESULT;
            valid_d = 1'b1;
          end else if (tick) begin
            presc_d = bus_if.N;
            if (react_max) begin
              state_d = S_RESULT;
              ovf_d   = 1'b1;
              valid_d = 1'b1;
            end else begin
              react_d = react_q + 1'b1;
            end
          end else begin
            presc_d = presc_q - 1'b1;
          end
        end
        default: ;  // IDLE waits for arm; RESULT holds until arm
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      btn_q   <= 1'b0;
      presc_q <= '0;
      react_q <= '0;
      valid_q <= 1'b0;
      foul_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= bus_if.btn;
      presc_q <= presc_d;
      react_q <= react_d;
      valid_q <= valid_d;
      foul_q  <= foul_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_if.react_time = react_q;
  assign bus_if.valid      = valid_q;
  assign bus_if.foul       = foul_q;
  assign bus_if.ovf        = ovf_q;
  assign bus_if.busy       = (state_q == S_ARMED) || (state_q == S_TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: drives a 16-bit and a 4-bit reaction timer with the same
// stimulus and checks both against an event-time model every cycle.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        go;
  logic        btn;
  logic [15:0] n_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reaction_timer_if #(.WIDTH(16)) if16 ();
  reaction_timer_if #(.WIDTH(4))  if4  ();

  assign if16.arm = arm;
  assign if16.go  = go;
  assign if16.btn = btn;
  assign if16.N   = n_val;
  assign if4.arm  = arm;
  assign if4.go   = go;
  assign if4.btn  = btn;
  assign if4.N    = n_val[3:0];

  reaction_timer #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus_if(if16));
  reaction_timer #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus_if(if4));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: measurement phase per instance (0 idle, 1 waiting for go,
  // 2 counting, 3 result shown). While counting, the value is derived from
  // elapsed cycles since go: floor(elapsed/(N+1)), saturating at 2^W (N+1).
  int     WV [2]      = '{16, 4};
  int     m_mode [2]  = '{0, 0};
  longint m_g [2]     = '{0, 0};
  longint m_n [2]     = '{0, 0};
  longint m_react [2] = '{0, 0};
  bit     m_valid [2] = '{0, 0};
  bit     m_foul [2]  = '{0, 0};
  bit     m_ovf [2]   = '{0, 0};
  bit     m_bprev     = 1'b0;
  longint cyc         = 0;

  always @(posedge clk) begin
    bit          press;
    longint      maxv;
    longint      sat;
    logic [63:0] a_r, a_v, a_f, a_o, a_b;
    cyc++;
    press   = btn && !m_bprev;
    m_bprev = rst ? 1'b0 : btn;
    for (int i = 0; i < 2; i++) begin
      maxv = (longint'(1) << WV[i]) - 1;
      m_valid[i] = 1'b0;
      if (rst) begin
        m_mode[i] = 0; m_react[i] = 0; m_foul[i] = 0; m_ovf[i] = 0;
      end else if (arm) begin
        m_mode[i] = 1; m_react[i] = 0; m_foul[i] = 0; m_ovf[i] = 0;
      end else if (m_mode[i] == 1) begin
        if (press) begin
          m_mode[i] = 3; m_foul[i] = 1; m_react[i] = 0; m_valid[i] = 1;
        end else if (go) begin
          m_mode[i] = 2; m_g[i] = cyc; m_react[i] = 0;
          m_n[i] = (i == 0) ? longint'(n_val) : longint'(n_val[3:0]);
        end
      end else if (m_mode[i] == 2) begin
        sat = m_g[i] + (maxv + 1) * (m_n[i] + 1);
        if (press) begin
          m_react[i] = (cyc - m_g[i] - 1) / (m_n[i] + 1);
          m_mode[i] = 3; m_valid[i] = 1;
        end else if (cyc == sat) begin
          m_react[i] = maxv; m_ovf[i] = 1; m_mode[i] = 3; m_valid[i] = 1;
        end else begin
          m_react[i] = (cyc - m_g[i]) / (m_n[i] + 1);
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        a_r = 64'(if16.react_time); a_v = 64'(if16.valid); a_f = 64'(if16.foul);
        a_o = 64'(if16.ovf);        a_b = 64'(if16.busy);
      end else begin
        a_r = 64'(if4.react_time);  a_v = 64'(if4.valid);  a_f = 64'(if4.foul);
        a_o = 64'(if4.ovf);         a_b = 64'(if4.busy);
      end
      chk($sformatf("react_w%0d", WV[i]), a_r, 64'(m_react[i]));
      chk($sformatf("valid_w%0d", WV[i]), a_v, 64'(m_valid[i]));
      chk($sformatf("foul_w%0d", WV[i]),  a_f, 64'(m_foul[i]));
      chk($sformatf("ovf_w%0d", WV[i]),   a_o, 64'(m_ovf[i]));
      chk($sformatf("busy_w%0d", WV[i]),  a_b, 64'(m_mode[i] == 1 || m_mode[i] == 2));
    end
  end

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    nxt(1);
    arm = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; go = 1'b0; btn = 1'b0; n_val = '0;
    nxt(2);
    chk("lit_rst_react", 64'(if16.react_time), 0);
    chk("lit_rst_busy",  64'(if16.busy), 0);
    chk("lit_rst_valid", 64'(if16.valid), 0);
    rst = 1'b0;

    // Normal: N=3, press 42 cycles after go -> 10
    n_val = 16'd3;
    pulse_arm();
    go = 1'b1;
    nxt(42);
    btn = 1'b1;
    nxt(1);
    chk("lit_norm_react", 64'(if16.react_time), 10);
    chk("lit_norm_valid", 64'(if16.valid), 1);
    chk("lit_norm_foul",  64'(if16.foul), 0);
    chk("lit_norm_ovf",   64'(if16.ovf), 0);
    nxt(1);
    chk("lit_norm_valid_off", 64'(if16.valid), 0);
    chk("lit_norm_busy_off",  64'(if16.busy), 0);
    btn = 1'b0; go = 1'b0;
    nxt(1);

    // Jump start, then a late go is ignored
    pulse_arm();
    nxt(4);
    btn = 1'b1;
    nxt(1);
    chk("lit_jump_foul",  64'(if16.foul), 1);
    chk("lit_jump_valid", 64'(if16.valid), 1);
    chk("lit_jump_react", 64'(if16.react_time), 0);
    go = 1'b1;
    nxt(5);
    chk("lit_jump_hold_react", 64'(if16.react_time), 0);
    chk("lit_jump_hold_foul",  64'(if16.foul), 1);
    go = 1'b0; btn = 1'b0;
    nxt(1);

    // go and press in the same cycle -> foul
    pulse_arm();
    go = 1'b1; btn = 1'b1;
    nxt(1);
    chk("lit_simul_foul", 64'(if16.foul), 1);
    go = 1'b0; btn = 1'b0;
    nxt(1);

    // Button held from before arm is never a press
    btn = 1'b1;
    nxt(1);
    n_val = '0;
    pulse_arm();
    go = 1'b1;
    nxt(20);
    chk("lit_held_react", 64'(if16.react_time), 19);
    chk("lit_held_busy",  64'(if16.busy), 1);
    btn = 1'b0;
    nxt(1);
    btn = 1'b1;
    nxt(1);
    chk("lit_held_valid", 64'(if16.valid), 1);
    chk("lit_held_react2", 64'(if16.react_time), 20);
    btn = 1'b0; go = 1'b0;
    nxt(1);

    // Overflow on the 4-bit instance with N=0
    pulse_arm();
    go = 1'b1;
    nxt(16);
    chk("lit_ovf_pre_react", 64'(if4.react_time), 15);
    chk("lit_ovf_pre_ovf",   64'(if4.ovf), 0);
    nxt(1);
    chk("lit_ovf_react", 64'(if4.react_time), 15);
    chk("lit_ovf_ovf",   64'(if4.ovf), 1);
    chk("lit_ovf_valid", 64'(if4.valid), 1);
    btn = 1'b1;
    nxt(1);
    btn = 1'b0;
    nxt(1);
    chk("lit_ovf_hold_react", 64'(if4.react_time), 15);
    chk("lit_ovf_hold_valid", 64'(if4.valid), 0);
    go = 1'b0;
    nxt(1);

    // Re-arm mid-timing, then reset mid-timing, then a normal run
    pulse_arm();
    go = 1'b1;
    nxt(6);
    chk("lit_rearm_pre", 64'(if16.react_time), 5);
    pulse_arm();
    chk("lit_rearm_react", 64'(if16.react_time), 0);
    chk("lit_rearm_busy",  64'(if16.busy), 1);
    chk("lit_rearm_valid", 64'(if16.valid), 0);
    nxt(3);
    rst = 1'b1;
    nxt(1);
    chk("lit_rstmid_busy",  64'(if16.busy), 0);
    chk("lit_rstmid_react", 64'(if16.react_time), 0);
    chk("lit_rstmid_valid", 64'(if16.valid), 0);
    rst = 1'b0; go = 1'b0;
    pulse_arm();
    go = 1'b1;
    nxt(4);
    btn = 1'b1;
    nxt(1);
    chk("lit_after_rst_react", 64'(if16.react_time), 3);
    chk("lit_after_rst_valid", 64'(if16.valid), 1);
    btn = 1'b0; go = 1'b0;
    nxt(1);

    // Press on the same edge as the 3rd tick at N=1 -> 2
    n_val = 16'd1;
    pulse_arm();
    go = 1'b1;
    nxt(6);
    btn = 1'b1;
    nxt(1);
    chk("lit_coll_react", 64'(if16.react_time), 2);
    btn = 1'b0; go = 1'b0;
    nxt(1);

    // Randomised traffic; N only changes while neither instance is counting
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      arm = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0)  go  = ~go;
      if ($urandom_range(0, 11) == 0) btn = ~btn;
      if (m_mode[0] != 2 && m_mode[1] != 2 && $urandom_range(0, 19) == 0)
        n_val = 16'($urandom_range(0, 3));
      nxt(1);
    end
    rst = 1'b0; arm = 1'b0;
    nxt(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Measures the player's response to the lights-out event produced by the start-light sequencer and its delay.
- Arms at the start of a light sequence. Flags a foul (jump start) if the button is pressed before lights-out.
- Otherwise counts prescaled time units from lights-out until the button press.
- Reports the result with a one-cycle valid strobe for the display and score path.

Parameters:
- WIDTH, 16, width of the reaction-time counter and the prescaler reload value N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  one-cycle pulse: a new light sequence has started.
- go  input  1  lights-out event; the delay block's time_out, sampled as a level.
- btn  input  1  player button, already synchronised, active-high level.
- N  input  WIDTH  prescaler reload; one time unit = N+1 clk cycles.
- react_time  output  WIDTH  measured time units; held until the next arm.
- valid  output  1  one-cycle pulse when a result (normal, foul or overflow) is latched.
- foul  output  1  result was a jump start; held until the next arm.
- ovf  output  1  counter saturated before any press; held until the next arm.
- busy  output  1  high in ARMED or TIMING.

Behaviour:
- Reset: state=IDLE; react_time=0, valid=0, foul=0, ovf=0, busy=0; prescaler=0; btn_q=0.
- Reset mid-measurement returns to IDLE with no valid pulse.
- Press detection:
  - press = btn & ~btn_q; btn_q is registered every cycle in every state.
  - A held button never produces a second press.
  - A button held through arm is not a press.
- States: IDLE, ARMED, TIMING, RESULT.
- IDLE:
  - arm -> ARMED; clear react_time, foul, ovf.
- ARMED:
  - press -> RESULT; foul=1, react_time=0, valid=1 next cycle.
  - go without press -> TIMING; prescaler loaded with N, react_time=0.
  - press and go in the same cycle: foul (press has priority).
- TIMING:
  - Prescaler counts down each cycle; tick when prescaler==0, then reload N.
  - N=0 gives a tick every cycle.
  - On tick: react_time+1.
  - press -> RESULT, valid pulse; react_time frozen. Press has priority over a same-cycle tick, so that increment is dropped.
  - Tick while react_time is all ones -> RESULT; ovf=1, react_time stays all ones, valid pulse.
  - go ignored.
- RESULT:
  - Outputs held; press and go ignored.
  - arm -> ARMED with clear.
- arm in ARMED or TIMING: restart -> ARMED; clear react_time, foul, ovf; no valid pulse.
- arm outranks press and go in the same cycle, in every state.
- Latency: event sampled at edge t -> state and outputs updated after edge t; valid high in the cycle following edge t, low after one cycle.
- Timing relation: go sampled at edge g, press sampled at edge g+c (c>=1) -> react_time = floor((c-1)/(N+1)), absent saturation.
- busy is combinational from state: 1 in ARMED or TIMING, 0 otherwise.
- N is sampled only at prescaler load and reload; changing N mid-run affects the next reload only.

Test Plan:
- Normal: WIDTH=16, N=3; arm, go at edge g, btn rises sampled at g+42 -> react_time=10, foul=0, ovf=0, valid high exactly one cycle, busy drops.
- Jump start: arm, btn rises 5 cycles later, go never -> RESULT, foul=1, react_time=0, valid pulse; a later go is ignored and react_time stays 0.
- Simultaneous and held: go and btn rise in the same cycle -> foul=1. Separately, btn held high from before arm, go, no new edge for 20 cycles at N=0 -> react_time=19, no result until btn falls and rises again.
- Overflow: WIDTH=4, N=0; arm, go, no press -> after tick at g+16, react_time=15, ovf=1, valid pulse; subsequent btn ignored.
- Re-arm and reset: mid-TIMING (react_time=5) pulse arm -> ARMED, react_time=0, no valid. Then go plus rst asserted mid-TIMING -> IDLE, all outputs 0, no valid; next arm works normally.
- Tick/press collision: N=1; press sampled on the same edge as the 3rd tick -> react_time=2, not 3.
